// File: rtl/debug_pkg.sv
// Shared state encoding and UART command bytes for the debug run controller.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_LATCH,
        SEND,
        WAIT
    } state_t;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    localparam logic [7:0] CMD_RST  = 8'h72;
    localparam logic [7:0] CMD_HALT = 8'h68;

endpackage

// File: rtl/word_tx_serializer.sv
// Sends one 32-bit word as four bytes, MSB first, over a tx_start/tx_done
// handshake and pulses o_word_done once the fourth byte has completed.
module word_tx_serializer
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    output logic        o_word_done
);

    state_t      r_state;
    logic [31:0] r_sr;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic        r_word_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_word_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_byte_cnt <= '0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    r_tx_data  <= r_sr[31:24];
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // tx_done is only meaningful here; a new byte never starts before it.
                    if (i_tx_done) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_word_done <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_state <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shift register is pure data: loaded on accept, shifted as each byte completes.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_load) begin
            r_sr <= i_word;
        end else if (r_state == WAIT && i_tx_done) begin
            r_sr <= {r_sr[23:0], 8'h00};
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_word_done = r_word_done;

endmodule

// File: rtl/debug_run_controller.sv
// UART debug sequencer: decodes commands, gates the pipeline enable for run or
// single-step, and streams a snapshot of datapath words plus the cycle count.
module debug_run_controller
    import debug_pkg::*;
#(
    parameter int          NUM_WORDS = 33,
    parameter int          AW        = 6,
    parameter logic [31:0] CNT_INIT  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    input  logic          halt_detected,
    output logic          pipe_enable,
    output logic          pipe_reset,
    output logic [AW-1:0] dump_addr,
    input  logic [31:0]   dump_word,
    output logic          busy
);

    localparam int            IW       = $clog2(NUM_WORDS + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS);
    localparam logic [AW-1:0] TOP_ADDR = AW'(NUM_WORDS - 1);

    state_t        r_state;
    logic [31:0]   r_cycle_cnt;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_dump_addr;
    logic          r_pipe_reset;

    logic          w_load;
    logic [31:0]   w_load_word;
    logic          w_word_done;
    logic [IW-1:0] w_next_idx;
    logic          w_halt_cmd;

    assign pipe_enable = (r_state == RUN && !halt_detected) || (r_state == STEP);
    assign w_halt_cmd  = rx_valid && (rx_data == CMD_HALT);
    assign w_next_idx  = r_idx + IW'(1);

    // The extra index past the datapath words carries the controller's own counter.
    assign w_load      = (r_state == DUMP_LATCH);
    assign w_load_word = (r_idx == LAST_IDX) ? r_cycle_cnt : dump_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cycle_cnt  <= CNT_INIT;
            r_idx        <= '0;
            r_dump_addr  <= '0;
            r_pipe_reset <= 1'b0;
        end else begin
            r_pipe_reset <= 1'b0;
            if (pipe_enable) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RUN:  r_state <= RUN;
                            CMD_STEP: r_state <= STEP;
                            CMD_DUMP: begin
                                r_idx       <= '0;
                                r_dump_addr <= '0;
                                r_state     <= DUMP_ADDR;
                            end
                            CMD_RST: begin
                                r_pipe_reset <= 1'b1;
                                r_cycle_cnt  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (halt_detected || w_halt_cmd) begin
                        r_state <= DUMP_ADDR;
                    end
                end
                STEP:       r_state <= DUMP_ADDR;
                DUMP_ADDR:  r_state <= DUMP_LATCH;
                DUMP_LATCH: r_state <= SEND;
                SEND: begin
                    // SEND here covers the whole serializer handshake for one word.
                    if (w_word_done) begin
                        if (w_next_idx <= LAST_IDX) begin
                            r_idx       <= w_next_idx;
                            r_dump_addr <= (w_next_idx == LAST_IDX) ? TOP_ADDR : AW'(w_next_idx);
                            r_state     <= DUMP_ADDR;
                        end else begin
                            r_idx       <= '0;
                            r_dump_addr <= '0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    word_tx_serializer u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_word      (w_load_word),
        .i_tx_done   (tx_done),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_word_done (w_word_done)
    );

    assign pipe_reset = r_pipe_reset;
    assign dump_addr  = r_dump_addr;
    assign busy       = (r_state != IDLE);

endmodule
